shift_share_arb: RTL and testbench

- Shares one combinational 32-bit left shifter (the SHIFT_LEFT datapath) among NUM_REQ requesters, e.g. the normalise, align and Taylor-term-scale stages of the Nroot unit.
- Round-robin arbitration, valid/ready request handshake, single registered result slot with valid/ready response handshake.
- Sustains one shift per cycle when the consumer keeps rsp_ready high.

---
 rtl/shift_arb_pkg.sv | 56 +++++
 rtl/shift_share_arb_shift_left.sv | 22 ++
 rtl/shift_share_arb.sv | 154 +++++++++++++++
 tb/tb_shift_share_arb.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_arb_pkg.sv
// -----------------------------------------------------------------------------
// shift_arb_pkg
// Shared definitions for the shared left-shifter arbiter:
//   - default operand / shift-amount widths
//   - result-slot state encoding (EMPTY=0, FULL=1)
//   - grant record and the round-robin next-grant search
// Optional feature macro used by the top: SHIFT_ARB_OVF_EN
// -----------------------------------------------------------------------------
package shift_arb_pkg;

   localparam int DATA_WIDTH_DEF   = 32;
   localparam int SELECT_WIDTH_DEF = 5;

   // The search works on a fixed-width vector so one function serves every NUM_REQ.
   localparam int MAX_REQ = 8;
   localparam int IDX_W   = 3;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } slot_state_t;

   typedef struct packed {
      logic             hit;
      logic [IDX_W-1:0] idx;
   } grant_t;

   // First valid requester at or above ptr, wrapping at num_req.
   // ptr must be below num_req; bits at or above num_req are ignored.
   function automatic grant_t rr_next_grant(
      input logic [MAX_REQ-1:0] valid,
      input logic [IDX_W-1:0]   ptr,
      input int unsigned        num_req
   );
      grant_t      g;
      int unsigned j;
      g.hit = 1'b0;
      g.idx = {IDX_W{1'b0}};
      for (int unsigned k = 0; k < MAX_REQ; k++) begin
         j = 32'(ptr) + k;
         if (j >= num_req) begin
            j = j - num_req;
         end else begin
            j = j;
         end
         if ((k < num_req) && !g.hit && valid[j[IDX_W-1:0]]) begin
            g.hit = 1'b1;
            g.idx = j[IDX_W-1:0];
         end else begin
            g = g;
         end
      end
      return g;
   endfunction

endpackage

// File: rtl/shift_share_arb_shift_left.sv
// -----------------------------------------------------------------------------
// SHIFT_LEFT
// Combinational logical left shifter, zero-filled from the bottom.
// Ports:
//   i_data  [DATA_WIDTH-1:0]   operand
//   i_shift [SELECT_WIDTH-1:0] shift amount (0 .. 2^SELECT_WIDTH-1)
//   o_data  [DATA_WIDTH-1:0]   i_data << i_shift
// -----------------------------------------------------------------------------
module SHIFT_LEFT
   import shift_arb_pkg::*;
#(
   parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
   parameter int SELECT_WIDTH = SELECT_WIDTH_DEF
) (
   input  logic [DATA_WIDTH-1:0]   i_data,
   input  logic [SELECT_WIDTH-1:0] i_shift,
   output logic [DATA_WIDTH-1:0]   o_data
);

   assign o_data = i_data << i_shift;

endmodule

// File: rtl/shift_share_arb.sv
// -----------------------------------------------------------------------------
// shift_share_arb
// Shares one SHIFT_LEFT instance among NUM_REQ requesters. Round-robin grant,
// valid/ready on each request, one registered result slot with valid/ready on
// the response side. Back-to-back accepts give one shift per cycle.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      per-requester handshake (req_ready one-hot or 0)
//   req_data, req_shift      packed operands / shift amounts, requester i at
//                            [i*W +: W]
//   rsp_valid/rsp_ready      result slot handshake
//   rsp_data, rsp_id         registered shift result and owning requester
//   rsp_ovf                  (only with SHIFT_ARB_OVF_EN) a 1 bit was shifted
//                            out of the top
// Optional feature macro: SHIFT_ARB_OVF_EN
// -----------------------------------------------------------------------------
module shift_share_arb
   import shift_arb_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
   parameter int SELECT_WIDTH = SELECT_WIDTH_DEF,
   parameter int ID_WIDTH     = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_REQ-1:0]              req_valid,
   output logic [NUM_REQ-1:0]              req_ready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
   input  logic [NUM_REQ*SELECT_WIDTH-1:0] req_shift,
   output logic                            rsp_valid,
   input  logic                            rsp_ready,
   output logic [DATA_WIDTH-1:0]           rsp_data,
   output logic [ID_WIDTH-1:0]             rsp_id
`ifdef SHIFT_ARB_OVF_EN
   ,
   output logic                            rsp_ovf
`endif
);

   localparam int unsigned NUM_REQ_U = NUM_REQ;

   logic [MAX_REQ-1:0]      w_valid_ext;
   grant_t                  w_grant;
   logic                    w_can_accept;
   logic                    w_do_grant;
   logic [DATA_WIDTH-1:0]   w_sel_data;
   logic [SELECT_WIDTH-1:0] w_sel_shift;
   logic [DATA_WIDTH-1:0]   w_shifted;
   logic [IDX_W-1:0]        w_ptr_next;

   slot_state_t             r_state;
   logic [DATA_WIDTH-1:0]   r_data;
   logic [ID_WIDTH-1:0]     r_id;
   logic [IDX_W-1:0]        r_ptr;

   // Zero-extend the valid vector to the width the search function expects.
   always_comb begin
      w_valid_ext = {MAX_REQ{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) begin
         w_valid_ext[i] = req_valid[i];
      end
   end

   // Round-robin candidate and whether it can actually be accepted this cycle.
   always_comb begin
      w_grant      = rr_next_grant(w_valid_ext, r_ptr, NUM_REQ_U);
      w_can_accept = (r_state == ST_EMPTY) || rsp_ready;
      // Gating with rst keeps req_ready low for the whole reset interval.
      w_do_grant   = w_can_accept && w_grant.hit && !rst;
      if (w_grant.idx == IDX_W'(NUM_REQ - 1)) begin
         w_ptr_next = {IDX_W{1'b0}};
      end else begin
         w_ptr_next = w_grant.idx + IDX_W'(1);
      end
   end

   // Grant decode and AND-OR operand mux feeding the shared shifter.
   always_comb begin
      req_ready   = {NUM_REQ{1'b0}};
      w_sel_data  = {DATA_WIDTH{1'b0}};
      w_sel_shift = {SELECT_WIDTH{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready[i] = w_do_grant && (w_grant.idx == IDX_W'(i));
         w_sel_data   = w_sel_data |
                        (req_data[i*DATA_WIDTH +: DATA_WIDTH] &
                         {DATA_WIDTH{w_grant.idx == IDX_W'(i)}});
         w_sel_shift  = w_sel_shift |
                        (req_shift[i*SELECT_WIDTH +: SELECT_WIDTH] &
                         {SELECT_WIDTH{w_grant.idx == IDX_W'(i)}});
      end
   end

   SHIFT_LEFT #(
      .DATA_WIDTH   (DATA_WIDTH),
      .SELECT_WIDTH (SELECT_WIDTH)
   ) u_shift_left (
      .i_data  (w_sel_data),
      .i_shift (w_sel_shift),
      .o_data  (w_shifted)
   );

   // Slot state, result register and round-robin pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_EMPTY;
         r_data  <= {DATA_WIDTH{1'b0}};
         r_id    <= {ID_WIDTH{1'b0}};
         r_ptr   <= {IDX_W{1'b0}};
      end else if (w_do_grant) begin
         // Also covers FULL drained and refilled in the same cycle.
         r_state <= ST_FULL;
         r_data  <= w_shifted;
         r_id    <= ID_WIDTH'(w_grant.idx);
         r_ptr   <= w_ptr_next;
      end else if ((r_state == ST_FULL) && rsp_ready) begin
         r_state <= ST_EMPTY;
         r_data  <= r_data;
         r_id    <= r_id;
         r_ptr   <= r_ptr;
      end else begin
         r_state <= r_state;
         r_data  <= r_data;
         r_id    <= r_id;
         r_ptr   <= r_ptr;
      end
   end

   assign rsp_valid = (r_state == ST_FULL);
   assign rsp_data  = r_data;
   assign rsp_id    = r_id;

`ifdef SHIFT_ARB_OVF_EN
   logic [DATA_WIDTH-1:0] w_spill;
   logic                  r_ovf;

   // Bits pushed past the top land in the upper half of a double-width shift.
   assign w_spill = DATA_WIDTH'(({{DATA_WIDTH{1'b0}}, w_sel_data} << w_sel_shift) >> DATA_WIDTH);

   // Overflow flag, loaded together with the result register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if (w_do_grant) begin
         r_ovf <= |w_spill;
      end else begin
         r_ovf <= r_ovf;
      end
   end

   assign rsp_ovf = r_ovf;
`endif

endmodule

// File: tb/tb_shift_share_arb.sv
module tb_shift_share_arb;

   logic         clk;
   logic         rst;
   logic [3:0]   req_valid;
   logic [3:0]   req_ready;
   logic [127:0] req_data;
   logic [19:0]  req_shift;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [31:0]  rsp_data;
   logic [1:0]   rsp_id;
`ifdef SHIFT_ARB_OVF_EN
   logic         rsp_ovf;
`endif

   int total;
   int bad;

   shift_share_arb #(
      .NUM_REQ      (4),
      .DATA_WIDTH   (32),
      .SELECT_WIDTH (5),
      .ID_WIDTH     (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data  (req_data),
      .req_shift (req_shift),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id)
`ifdef SHIFT_ARB_OVF_EN
      ,
      .rsp_ovf   (rsp_ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          idx;
      logic [31:0] data;
      logic [4:0]  shift;
      logic [31:0] exp_data;
      logic        exp_ovf;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      rst       = 1'b1;
      req_valid = 4'hF;
      rsp_ready = 1'b1;
      req_data  = 128'd0;
      req_shift = 20'd0;
      req_data[31:0] = 32'h0000_0001;

      vecs[0] = '{1, 32'h8000_0001, 5'd0,  32'h8000_0001, 1'b0};
      vecs[1] = '{3, 32'h8000_0001, 5'd31, 32'h8000_0000, 1'b1};
      vecs[2] = '{0, 32'h8000_0001, 5'd1,  32'h0000_0002, 1'b1};
      vecs[3] = '{2, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0};
      vecs[4] = '{1, 32'hFFFF_FFFF, 5'd16, 32'hFFFF_0000, 1'b1};
      vecs[5] = '{0, 32'h0000_FFFF, 5'd16, 32'hFFFF_0000, 1'b0};
      vecs[6] = '{3, 32'h1234_5678, 5'd4,  32'h2345_6780, 1'b1};
      vecs[7] = '{2, 32'h0F00_0000, 5'd4,  32'hF000_0000, 1'b0};

      // Reset held for 3 cycles with every requester valid
      step(); step(); step();
      chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_ready", {28'd0, req_ready}, 32'd0);
      chk("rst_data",  rsp_data, 32'd0);
      chk("rst_id",    {30'd0, rsp_id}, 32'd0);
      rst = 1'b0;
      #1;
      chk("first_grant", {28'd0, req_ready}, 32'h1);
      step();
      chk("first_valid", {31'd0, rsp_valid}, 32'd1);
      chk("first_id",    {30'd0, rsp_id}, 32'd0);
      chk("first_data",  rsp_data, 32'h0000_0001);
      req_valid = 4'h0;
      step();
      chk("drain_valid", {31'd0, rsp_valid}, 32'd0);

      // Single request from requester 2
      req_data[2*32 +: 32] = 32'h0000_00F1;
      req_shift[2*5 +: 5]  = 5'd4;
      req_valid = 4'b0100;
      #1;
      chk("single_ready", {28'd0, req_ready}, 32'h4);
      step();
      req_valid = 4'h0;
      #1;
      chk("single_ready_off", {28'd0, req_ready}, 32'h0);
      chk("single_valid", {31'd0, rsp_valid}, 32'd1);
      chk("single_data",  rsp_data, 32'h0000_0F10);
      chk("single_id",    {30'd0, rsp_id}, 32'd2);
      step();
      chk("single_drain", {31'd0, rsp_valid}, 32'd0);

      // Shift table, one requester at a time
      for (int v = 0; v < 8; v++) begin
         req_data[vecs[v].idx*32 +: 32] = vecs[v].data;
         req_shift[vecs[v].idx*5 +: 5]  = vecs[v].shift;
         req_valid = 4'h0;
         req_valid[vecs[v].idx] = 1'b1;
         #1;
         chk($sformatf("tab%0d_ready", v), {28'd0, req_ready}, 32'(4'b0001 << vecs[v].idx));
         step();
         req_valid = 4'h0;
         chk($sformatf("tab%0d_valid", v), {31'd0, rsp_valid}, 32'd1);
         chk($sformatf("tab%0d_data", v), rsp_data, vecs[v].exp_data);
         chk($sformatf("tab%0d_id", v), {30'd0, rsp_id}, 32'(vecs[v].idx));
`ifdef SHIFT_ARB_OVF_EN
         chk($sformatf("tab%0d_ovf", v), {31'd0, rsp_ovf}, {31'd0, vecs[v].exp_ovf});
`endif
         step();
         chk($sformatf("tab%0d_drain", v), {31'd0, rsp_valid}, 32'd0);
      end

      // Short reset pulse, then round-robin with all requesters valid
      rst = 1'b1;
      #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         req_data[i*32 +: 32] = 32'(i + 1);
         req_shift[i*5 +: 5]  = 5'd1;
      end
      req_valid = 4'hF;
      rsp_ready = 1'b1;
      #1;
      chk("rr_first_ready", {28'd0, req_ready}, 32'h1);
      for (int k = 0; k < 8; k++) begin
         step();
         chk($sformatf("rr%0d_valid", k), {31'd0, rsp_valid}, 32'd1);
         chk($sformatf("rr%0d_id", k), {30'd0, rsp_id}, 32'(k % 4));
         chk($sformatf("rr%0d_data", k), rsp_data, 32'(((k % 4) + 1) * 2));
      end

      // Backpressure: slot holds requester 3's result
      rsp_ready = 1'b0;
      #1;
      chk("bp_ready_off", {28'd0, req_ready}, 32'h0);
      for (int c = 0; c < 5; c++) begin
         step();
         chk($sformatf("bp%0d_valid", c), {31'd0, rsp_valid}, 32'd1);
         chk($sformatf("bp%0d_id", c), {30'd0, rsp_id}, 32'd3);
         chk($sformatf("bp%0d_data", c), rsp_data, 32'd8);
         chk($sformatf("bp%0d_ready", c), {28'd0, req_ready}, 32'h0);
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp_release_ready", {28'd0, req_ready}, 32'h1);
      step();
      chk("bp_release_id",   {30'd0, rsp_id}, 32'd0);
      chk("bp_release_data", rsp_data, 32'd2);

      // Move pointer to 3, fill the slot, then reset while it is stalled
      req_valid = 4'b0100;
      step();
      chk("pre_rst_id", {30'd0, rsp_id}, 32'd2);
      rsp_ready = 1'b0;
      req_valid = 4'hF;
      step();
      chk("pre_rst_valid", {31'd0, rsp_valid}, 32'd1);
      chk("pre_rst_hold_id", {30'd0, rsp_id}, 32'd2);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
      chk("mid_rst_data",  rsp_data, 32'd0);
      chk("mid_rst_ready", {28'd0, req_ready}, 32'h0);
      step();
      rst = 1'b0;
      rsp_ready = 1'b1;
      #1;
      chk("post_rst_ready", {28'd0, req_ready}, 32'h1);
      step();
      chk("post_rst_id",    {30'd0, rsp_id}, 32'd0);
      chk("post_rst_valid", {31'd0, rsp_valid}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
